// File: rtl/lsu_dmem_ctrl.sv
// MEM-stage load/store unit: aligns stores, extends loads, stalls the pipeline
// around each data-bus transaction and records the first misaligned access.
module lsu_dmem_ctrl #(
  parameter int XLEN      = 32,
  parameter int ADDR_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 memreadM,
  input  logic                 memwriteM,
  input  logic [1:0]           lwhbM,
  input  logic [1:0]           swhbM,
  input  logic                 lunsignedM,
  input  logic [XLEN-1:0]      addrM,
  input  logic [XLEN-1:0]      writedataM,
  input  logic [ADDR_SIZE-1:0] pcM,
  output logic [XLEN-1:0]      readdataM,
  output logic                 stallM,
  output logic                 misalignM,
  output logic [XLEN-1:0]      badaddr,
  output logic [ADDR_SIZE-1:0] badpc,
  output logic                 dreq,
  output logic                 dwe,
  output logic [XLEN-1:0]      daddr,
  output logic [3:0]           dbe,
  output logic [XLEN-1:0]      dwdata,
  input  logic                 dgnt,
  input  logic                 drvalid,
  input  logic [XLEN-1:0]      drdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t     state, stateNext;
  logic       accessValid, misaligned, accept;
  logic [1:0] accSize;
  logic [3:0] beNext;
  logic [XLEN-1:0] wdataNext, loadExt;
  logic [1:0] addrLoReg, sizeReg;
  logic       unsignedReg, badValid;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  assign accessValid = memwriteM | memreadM;
  assign accSize     = memwriteM ? swhbM : lwhbM;
  assign misaligned  = ((accSize == 2'b01) & addrM[0]) |
                       (accSize[1] & (addrM[1:0] != 2'b00));
  assign accept      = accessValid & ~misaligned;

  assign stallM    = accept & (state != DONE) & ~reset;
  assign misalignM = accessValid & misaligned & ~reset;
  assign dreq      = (state == REQ);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    beNext    = 4'b1111;
    wdataNext = writedataM;
    case (accSize)
      2'b00: begin
        beNext    = 4'b0001 << addrM[1:0];
        wdataNext = {(XLEN/8){writedataM[7:0]}};
      end
      2'b01: begin
        beNext    = addrM[1] ? 4'b1100 : 4'b0011;
        wdataNext = {(XLEN/16){writedataM[15:0]}};
      end
      default: ;
    endcase
  end

  // Extraction uses the copies captured at accept, not the live MEM inputs.
  always_comb begin
    loadByte = drdata[7:0];
    case (addrLoReg)
      2'd1:    loadByte = drdata[15:8];
      2'd2:    loadByte = drdata[23:16];
      2'd3:    loadByte = drdata[31:24];
      default: ;
    endcase
    loadHalf = addrLoReg[1] ? drdata[31:16] : drdata[15:0];
    case (sizeReg)
      2'b00:   loadExt = {{(XLEN-8){~unsignedReg & loadByte[7]}}, loadByte};
      2'b01:   loadExt = {{(XLEN-16){~unsignedReg & loadHalf[15]}}, loadHalf};
      default: loadExt = drdata;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept)  stateNext = REQ;
      REQ:     if (dgnt)    stateNext = dwe ? DONE : WAIT;
      WAIT:    if (drvalid) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwe         <= 1'b0;
      daddr       <= '0;
      dbe         <= '0;
      dwdata      <= '0;
      addrLoReg   <= '0;
      sizeReg     <= '0;
      unsignedReg <= 1'b0;
      readdataM   <= '0;
    end else begin
      if (state == IDLE && accept) begin
        dwe         <= memwriteM;
        daddr       <= {addrM[XLEN-1:2], 2'b00};
        dbe         <= beNext;
        dwdata      <= wdataNext;
        addrLoReg   <= addrM[1:0];
        sizeReg     <= accSize;
        unsignedReg <= lunsignedM;
      end
      if (state == WAIT && drvalid) readdataM <= loadExt;
    end
  end

  // Only the first fault since reset is kept; later ones are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      badValid <= 1'b0;
      badaddr  <= '0;
      badpc    <= '0;
    end else if (misalignM && !badValid) begin
      badValid <= 1'b1;
      badaddr  <= addrM;
      badpc    <= pcM;
    end
  end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed bench for lsu_dmem_ctrl with a small bus responder and a queue of
// expected load results.
module tb_lsu_dmem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreadM, memwriteM, lunsignedM;
  logic [1:0]  lwhbM, swhbM;
  logic [31:0] addrM, writedataM, pcM;
  logic [31:0] readdataM, badaddr, badpc, daddr, dwdata, drdata;
  logic        stallM, misalignM, dreq, dwe, dgnt, drvalid;
  logic [3:0]  dbe;

  int checks = 0;
  int failures = 0;
  logic [31:0] expQ[$];
  logic [31:0] lastRd = '0;

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.XLEN(32), .ADDR_SIZE(32)) dut (
    .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM),
    .lwhbM(lwhbM), .swhbM(swhbM), .lunsignedM(lunsignedM), .addrM(addrM),
    .writedataM(writedataM), .pcM(pcM), .readdataM(readdataM), .stallM(stallM),
    .misalignM(misalignM), .badaddr(badaddr), .badpc(badpc), .dreq(dreq),
    .dwe(dwe), .daddr(daddr), .dbe(dbe), .dwdata(dwdata), .dgnt(dgnt),
    .drvalid(drvalid), .drdata(drdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idleInputs();
    memreadM  = 1'b0;
    memwriteM = 1'b0;
    dgnt      = 1'b0;
    drvalid   = 1'b0;
  endtask

  // Drives one access and acts as the bus: grants after gntDelay extra REQ
  // cycles and returns rdata in the first WAIT cycle.
  task automatic access(input string tag, input logic wr, input logic rd,
                        input logic [1:0] ssz, input logic [1:0] lsz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                        input int gntDelay, input logic [31:0] expAddr, input logic [3:0] expDbe,
                        input logic [31:0] expWdata, input int expStall, input int expReq,
                        input logic [31:0] expRd);
    int  stallCnt = 0;
    int  reqCnt = 0;
    bit  granted = 0;
    bit  done = 0;
    bit  isLoad;
    isLoad = rd && !wr;
    @(negedge clk);
    memwriteM = wr; memreadM = rd; swhbM = ssz; lwhbM = lsz; lunsignedM = uns;
    addrM = addr; writedataM = wd; pcM = 32'h1000; drdata = rdata;
    dgnt = 1'b0; drvalid = 1'b0;
    if (isLoad) expQ.push_back(expRd);
    #1;
    check({tag, " misalignM"}, {31'b0, misalignM}, 32'd0);
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (!stallM) begin
        done = 1;
      end else begin
        stallCnt++;
        dgnt = 1'b0;
        drvalid = 1'b0;
        if (dreq) begin
          reqCnt++;
          check({tag, " daddr"}, daddr, expAddr);
          check({tag, " dbe"}, {28'b0, dbe}, {28'b0, expDbe});
          check({tag, " dwdata"}, dwdata, expWdata);
          check({tag, " dwe"}, {31'b0, dwe}, {31'b0, wr});
          if (reqCnt > gntDelay) begin
            dgnt = 1'b1;
            granted = 1;
          end
        end else if (granted && isLoad) begin
          drvalid = 1'b1;
        end
        @(negedge clk);
        #1;
      end
    end
    check({tag, " completed"}, {31'b0, done}, 32'd1);
    check({tag, " stall cycles"}, stallCnt, expStall);
    check({tag, " req cycles"}, reqCnt, expReq);
    if (isLoad) begin
      if (expQ.size() > 0) lastRd = expQ.pop_front();
      check({tag, " readdataM"}, readdataM, lastRd);
    end else begin
      check({tag, " readdataM held"}, readdataM, lastRd);
    end
    idleInputs();
  endtask

  initial begin
    reset = 1'b1;
    idleInputs();
    lwhbM = 2'b10; swhbM = 2'b10; lunsignedM = 1'b0;
    addrM = 32'h100; writedataM = '0; pcM = '0; drdata = '0;
    memreadM = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("reset stallM", {31'b0, stallM}, 32'd0);
    check("reset dreq", {31'b0, dreq}, 32'd0);
    check("reset readdataM", readdataM, 32'd0);
    check("reset dbe", {28'b0, dbe}, 32'd0);
    check("reset badaddr", badaddr, 32'd0);
    check("reset badpc", badpc, 32'd0);
    addrM = 32'h101;
    #1;
    check("reset misalignM", {31'b0, misalignM}, 32'd0);
    @(negedge clk);
    memreadM = 1'b0;
    reset = 1'b0;

    access("lw", 0, 1, 2'b10, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0,
           32'h100, 4'b1111, 32'h0, 3, 1, 32'hDEADBEEF);
    access("lb", 0, 1, 2'b00, 2'b00, 0, 32'h103, 32'h0, 32'h80FF0000, 0,
           32'h100, 4'b1000, 32'h0, 3, 1, 32'hFFFFFF80);
    access("lbu", 0, 1, 2'b00, 2'b00, 1, 32'h103, 32'h0, 32'h80FF0000, 1,
           32'h100, 4'b1000, 32'h0, 4, 2, 32'h00000080);
    access("lh", 0, 1, 2'b01, 2'b01, 0, 32'h102, 32'h0, 32'h80FF0000, 0,
           32'h100, 4'b1100, 32'h0, 3, 1, 32'hFFFF80FF);
    access("lbu1", 0, 1, 2'b00, 2'b00, 1, 32'h205, 32'h0, 32'h0000F700, 0,
           32'h204, 4'b0010, 32'h0, 3, 1, 32'h000000F7);
    access("sh", 1, 0, 2'b01, 2'b01, 0, 32'h102, 32'h1234ABCD, 32'h0, 2,
           32'h100, 4'b1100, 32'hABCDABCD, 4, 3, 32'h0);

    // Misaligned word load, then a misaligned half store that must not recapture.
    @(negedge clk);
    memreadM = 1'b1; lwhbM = 2'b10; addrM = 32'h101; pcM = 32'h40;
    #1;
    check("mis lw misalignM", {31'b0, misalignM}, 32'd1);
    check("mis lw stallM", {31'b0, stallM}, 32'd0);
    check("mis lw dreq", {31'b0, dreq}, 32'd0);
    @(negedge clk);
    memreadM = 1'b0; memwriteM = 1'b1; swhbM = 2'b01; addrM = 32'h203; pcM = 32'h80;
    #1;
    check("mis lw badaddr", badaddr, 32'h101);
    check("mis lw badpc", badpc, 32'h40);
    check("mis sh misalignM", {31'b0, misalignM}, 32'd1);
    check("mis sh dreq", {31'b0, dreq}, 32'd0);
    @(negedge clk);
    idleInputs();
    #1;
    check("mis sh badaddr kept", badaddr, 32'h101);
    check("mis sh badpc kept", badpc, 32'h40);
    check("mis readdataM held", readdataM, lastRd);
    check("mis dreq after", {31'b0, dreq}, 32'd0);

    // Reset while waiting for load data.
    @(negedge clk);
    memreadM = 1'b1; lwhbM = 2'b10; addrM = 32'h100; pcM = 32'h50;
    @(negedge clk);
    #1;
    check("rst req dreq", {31'b0, dreq}, 32'd1);
    dgnt = 1'b1;
    @(negedge clk);
    dgnt = 1'b0;
    #1;
    check("rst wait dreq", {31'b0, dreq}, 32'd0);
    check("rst wait stallM", {31'b0, stallM}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst high stallM", {31'b0, stallM}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idleInputs();
    #1;
    check("rst after dreq", {31'b0, dreq}, 32'd0);
    check("rst after readdataM", readdataM, 32'd0);
    check("rst after badaddr", badaddr, 32'd0);
    drvalid = 1'b1; drdata = 32'h12345678;
    @(negedge clk);
    drvalid = 1'b0;
    #1;
    check("rst late drvalid readdataM", readdataM, 32'd0);
    check("rst late stallM", {31'b0, stallM}, 32'd0);
    lastRd = 32'h0;

    // Read and write together: the byte store wins, the word read size is ignored.
    access("rdwr sb", 1, 1, 2'b00, 2'b10, 0, 32'h001, 32'h000000AA, 32'h0, 0,
           32'h000, 4'b0010, 32'hAAAAAAAA, 2, 1, 32'h0);
    access("lhu", 0, 1, 2'b01, 2'b01, 1, 32'h100, 32'h0, 32'h80FF1234, 0,
           32'h100, 4'b0011, 32'h0, 3, 1, 32'h00001234);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_ctrl.md
# lsu_dmem_ctrl

Load/store unit in the MEM stage, between the pipeline's memory-stage outputs (ALU address, store data, control, pc) and a data-memory bus with a request/grant and read-valid handshake. It aligns store data and builds byte enables, extracts and sign- or zero-extends load data, and stalls the pipeline for the duration of each bus transaction. It detects misaligned accesses, which suppress the bus transaction, and records the first faulting address and pc.

## Interface
- XLEN, 32, data and address width
- ADDR_SIZE, 32, pc width
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high; clears all state at the next rising edge
- memreadM  in  1  load in MEM stage
- memwriteM  in  1  store in MEM stage; has priority over memreadM
- lwhbM  in  2  load size: 00 byte, 01 half, 10/11 word
- swhbM  in  2  store size, same encoding
- lunsignedM  in  1  1 = zero-extend load, 0 = sign-extend
- addrM  in  XLEN  byte address (ALU result)
- writedataM  in  XLEN  store data, right-aligned
- pcM  in  ADDR_SIZE  pc of the MEM-stage instruction
- readdataM  out  XLEN  extended load result, registered
- stallM  out  1  holds the whole pipeline
- misalignM  out  1  combinational misalign flag for the current access
- badaddr  out  XLEN  first misaligned address (sticky)
- badpc  out  ADDR_SIZE  pc of first misaligned access (sticky)
- dreq  out  1  bus request
- dwe  out  1  bus write
- daddr  out  XLEN  word address ({addrM[XLEN-1:2],2'b00})
- dbe  out  4  byte enables
- dwdata  out  XLEN  lane-replicated store data
- dgnt  in  1  bus accepts request
- drvalid  in  1  load data valid
- drdata  in  XLEN  load word

## Operation
- Access valid: memwriteM | memreadM. Size is swhbM for a write and lwhbM for a read.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
- A misaligned access produces:
  - misalignM=1, no bus request, stallM=0.
  - readdataM unchanged.
  - badaddr/badpc captured only if no earlier capture since reset; a sticky valid bit guards the capture.
- FSM states IDLE, REQ, WAIT, DONE:
  - IDLE: on a valid aligned access, register daddr/dbe/dwdata/dwe and go to REQ. drvalid and dgnt are ignored.
  - REQ: dreq=1. All bus outputs are held stable until dgnt. On dgnt, a store goes to DONE and a load goes to WAIT.
  - WAIT: dreq=0. On drvalid, register the extracted load result into readdataM and go to DONE.
  - DONE: go to IDLE unconditionally. The pipeline advances at the end of this cycle.
- stallM = valid & aligned & (state≠DONE) & !reset.
- Store lanes by size:
  - byte: dbe=0001<<addr[1:0], dwdata={4{wd[7:0]}}
  - half: dbe=addr[1]?1100:0011, dwdata={2{wd[15:0]}}
  - word: dbe=1111, dwdata=wd
- Load extraction:
  - Byte is drdata[8*addr[1:0]+:8]; half is drdata[16*addr[1]+:16].
  - Both are extended per lunsignedM; word is passed through.
  - The address and size used are the registered copies.
- Reset values: state IDLE; dreq, dwe, daddr, dbe, dwdata, readdataM, badaddr, badpc, sticky bit all 0. stallM=0 and misalignM=0 while reset is high.

## Timing
- Load minimum: IDLE(t), REQ(t+1, dgnt), WAIT(t+2, drvalid), DONE(t+3). stallM is high for t..t+2 and readdataM is valid at t+3.
- Store minimum: IDLE(t), REQ(t+1, dgnt), DONE(t+2). stallM is high for 2 cycles.
- Each cycle without dgnt in REQ, or without drvalid in WAIT, adds one stall cycle. There is no timeout.
- drvalid asserted in the same cycle as dgnt is ignored; the bus guarantees at least one cycle of gap.
- Reset mid-transaction (REQ or WAIT): IDLE and dreq=0 from the next cycle; a later drvalid is ignored and readdataM stays 0.
- memreadM and memwriteM both set: only the store is performed.
- readdataM holds its last value until the next load completes.

## Test plan
- lw at 0x100, dgnt immediate, drvalid one cycle later with 0xDEADBEEF -> stallM high 3 cycles, daddr=0x100, dbe=1111, dwe=0; readdataM=0xDEADBEEF in DONE.
- lb at 0x103, drdata=0x80FF0000 -> readdataM=0xFFFFFF80. Repeat as lbu -> 0x00000080. lh at 0x102 -> 0xFFFF80FF.
- sh at 0x102, writedataM=0x1234ABCD, dgnt delayed 2 cycles -> dreq high 3 cycles with stable dbe=1100, dwdata=0xABCDABCD, dwe=1; stallM high 4 cycles total.
- lw at 0x101, pcM=0x40 -> misalignM=1, dreq never rises, stallM=0, badaddr=0x101, badpc=0x40. A following sh at 0x203 leaves badaddr/badpc unchanged.
- Reset asserted during WAIT -> next cycle state IDLE, dreq=0, readdataM=0; a subsequent drvalid with 0x12345678 leaves readdataM=0.
- memreadM=memwriteM=1, sb at 0x001 with data 0xAA -> dwe=1, dbe=0010, dwdata=0xAAAAAAAA; no WAIT state.
